// File: rtl/frame_transmit.sv
// ============================================================================
// frame_transmit : 16-byte FIFO + serial frame transmitter (start, size, data, CRC-8, stop)
// Revision 1.0
// ============================================================================
`default_nettype none

module frame_transmit (
  input  logic       clk,
  input  logic       reset,
  input  logic       txfifowrite,
  input  logic [7:0] datain,
  input  logic       send,
  input  logic [7:0] baudrate,
  output logic       TX,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SIZE  = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  baud_cnt_q, baud_cnt_d;
  logic [7:0]  baud_lat_q, baud_lat_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  size_q, size_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  crc_q, crc_d;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        over_q, over_d;
  logic [7:0]  mem_q [16];

  logic        bit_end;
  logic        tx_bit;
  logic        pop;
  logic        wr_ok;
  logic        crc_fb;
  logic [7:0]  crc_step;

  assign bit_end  = (baud_cnt_q == baud_lat_q);
  assign crc_fb   = crc_q[7] ^ tx_bit;
  assign crc_step = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

  always_comb begin
    tx_bit = 1'b0;
    case (state_q)
      S_START: tx_bit = 1'b1;
      S_SIZE:  tx_bit = size_q[~bit_cnt_q[1:0]];
      S_DATA:  tx_bit = shift_q[7];
      S_CRC:   tx_bit = crc_q[7];
      default: tx_bit = 1'b0;
    endcase
  end

  // Each data byte is loaded into shift_q on the edge that opens its first bit,
  // so the FIFO pop coincides with the last clock of the preceding bit.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    baud_lat_d = baud_lat_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    size_d     = size_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    pop        = 1'b0;

    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_end ? 8'd0 : baud_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (send && !empty_q) begin
          state_d    = S_START;
          size_d     = count_q[4] ? 4'd15 : count_q[3:0];
          baud_lat_d = baudrate;
          baud_cnt_d = 8'd0;
          crc_d      = 8'h00;
          bit_cnt_d  = 5'd0;
          byte_cnt_d = 4'd0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_SIZE;
          bit_cnt_d = 5'd0;
        end
      end
      S_SIZE: begin
        if (bit_end) begin
          crc_d = crc_step;
          if (bit_cnt_q == 5'd3) begin
            state_d    = S_DATA;
            bit_cnt_d  = 5'd0;
            byte_cnt_d = 4'd0;
            pop        = 1'b1;
            shift_d    = mem_q[rd_ptr_q];
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          crc_d = crc_step;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            if (byte_cnt_q == size_q - 4'd1) begin
              state_d = S_CRC;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
              pop        = 1'b1;
              shift_d    = mem_q[rd_ptr_q];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end
      end
      S_CRC: begin
        if (bit_end) begin
          crc_d = {crc_q[6:0], 1'b0};
          if (bit_cnt_q == 5'd7) begin
            state_d   = S_STOP;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a full FIFO still takes the write.
  always_comb begin
    wr_ok    = txfifowrite && (!count_q[4] || pop);
    count_d  = count_q + {4'd0, wr_ok} - {4'd0, pop};
    wr_ptr_d = wr_ptr_q + {3'd0, wr_ok};
    rd_ptr_d = rd_ptr_q + {3'd0, pop};
    full_d   = (count_d == 5'd16);
    empty_d  = (count_d == 5'd0);
    over_d   = over_q || (txfifowrite && !wr_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= 8'd0;
      baud_lat_q <= 8'd0;
      bit_cnt_q  <= 5'd0;
      byte_cnt_q <= 4'd0;
      size_q     <= 4'd0;
      shift_q    <= 8'd0;
      crc_q      <= 8'd0;
      wr_ptr_q   <= 4'd0;
      rd_ptr_q   <= 4'd0;
      count_q    <= 5'd0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      baud_lat_q <= baud_lat_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      size_q     <= size_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      over_q     <= over_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= datain;
    end
  end

  assign TX    = tx_bit;
  assign busy  = (state_q != S_IDLE);
  assign full  = full_q;
  assign empty = empty_q;
  assign over  = over_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_transmit.sv
// Directed bench for frame_transmit: captures TX cycle by cycle while busy and compares it to expected frames.
`default_nettype none

module tb_frame_transmit;

  logic       clk = 1'b0;
  logic       reset;
  logic       txfifowrite;
  logic [7:0] datain;
  logic       send;
  logic [7:0] baudrate;
  logic       TX;
  logic       busy;
  logic       full;
  logic       empty;
  logic       over;

  int n_checks = 0;
  int n_pass   = 0;

  logic       cap[$];
  logic       exp_bits[$];
  logic [7:0] exp_bytes[$];
  logic       full_after_write;
  logic       timed_out;

  frame_transmit dut (
    .clk         (clk),
    .reset       (reset),
    .txfifowrite (txfifowrite),
    .datain      (datain),
    .send        (send),
    .baudrate    (baudrate),
    .TX          (TX),
    .busy        (busy),
    .full        (full),
    .empty       (empty),
    .over        (over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    txfifowrite = 1'b1;
    datain      = d;
    tick();
    txfifowrite = 1'b0;
  endtask

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Expected bit sequence from a size and exp_bytes, CRC computed bit by bit.
  task automatic make_exp(input logic [3:0] size);
    logic [7:0] c;
    logic [7:0] d;
    c = 8'h00;
    exp_bits.delete();
    exp_bits.push_back(1'b1);
    for (int i = 3; i >= 0; i--) begin
      exp_bits.push_back(size[i]);
      c = crc_bit(c, size[i]);
    end
    foreach (exp_bytes[k]) begin
      d = exp_bytes[k];
      for (int i = 7; i >= 0; i--) begin
        exp_bits.push_back(d[i]);
        c = crc_bit(c, d[i]);
      end
    end
    for (int i = 7; i >= 0; i--) exp_bits.push_back(c[i]);
    exp_bits.push_back(1'b0);
  endtask

  function automatic int stream_errs(input int b);
    int e;
    e = 0;
    for (int i = 0; i < cap.size(); i++) begin
      if (i / (b + 1) >= exp_bits.size()) e++;
      else if (cap[i] !== exp_bits[i / (b + 1)]) e++;
    end
    return e;
  endfunction

  // Pulses send, then records TX every cycle while busy; index 0 is the first start-bit cycle.
  task automatic run_frame(input int write_at, input logic [7:0] wdata,
                           input int chg_at, input logic [7:0] new_baud,
                           input int resend_at);
    int guard;
    cap.delete();
    send = 1'b1;
    tick();
    send = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 5000) begin
      cap.push_back(TX);
      if (guard == write_at) begin
        txfifowrite = 1'b1;
        datain      = wdata;
      end
      if (guard == chg_at) baudrate = new_baud;
      if (guard == resend_at) send = 1'b1;
      tick();
      if (guard == write_at) full_after_write = full;
      txfifowrite = 1'b0;
      send        = 1'b0;
      guard++;
    end
    timed_out = (guard >= 5000);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({TX, busy, full, empty, over} !== 5'b00010)
      $display("FAIL reset_outputs: TX/busy/full/empty/over got %b expected 00010", {TX, busy, full, empty, over});
    else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [21:0] k;
    int e;
    do_reset();
    write_byte(8'hA5);
    baudrate = 8'd3;
    run_frame(-1, 8'h00, -1, 8'h00, -1);
    k = 22'b1_0001_10100101_01100111_0;
    exp_bits.delete();
    for (int i = 21; i >= 0; i--) exp_bits.push_back(k[i]);
    n_checks++;
    if (timed_out || cap.size() != 88)
      $display("FAIL single_len: busy cycles got %0d expected 88", cap.size());
    else n_pass++;
    e = stream_errs(3);
    n_checks++;
    if (e != 0) $display("FAIL single_bits: %0d wrong TX cycles, expected 0", e);
    else n_pass++;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL single_empty: got %b expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int e;
    do_reset();
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    n_checks++;
    if ({full, over} !== 2'b10) $display("FAIL ovf_full16: full/over got %b expected 10", {full, over});
    else n_pass++;
    write_byte(8'h10);
    n_checks++;
    if ({full, over} !== 2'b11) $display("FAIL ovf_over17: full/over got %b expected 11", {full, over});
    else n_pass++;
    baudrate = 8'd1;
    run_frame(-1, 8'h00, -1, 8'h00, -1);
    exp_bytes.delete();
    for (int i = 0; i < 15; i++) exp_bytes.push_back(8'(i));
    make_exp(4'd15);
    e = stream_errs(1);
    n_checks++;
    if (timed_out || cap.size() != 134*2 || e != 0)
      $display("FAIL ovf_frame15: len %0d bad %0d expected len 268 bad 0", cap.size(), e);
    else n_pass++;
    run_frame(-1, 8'h00, -1, 8'h00, -1);
    exp_bytes.delete();
    exp_bytes.push_back(8'h0F);
    make_exp(4'd1);
    e = stream_errs(1);
    n_checks++;
    if (timed_out || cap.size() != 44 || e != 0)
      $display("FAIL ovf_frame1: len %0d bad %0d expected len 44 bad 0", cap.size(), e);
    else n_pass++;
    n_checks++;
    if ({empty, over} !== 2'b11) $display("FAIL ovf_after: empty/over got %b expected 11", {empty, over});
    else n_pass++;
  endtask

  task automatic test_baud_change();
    int e;
    do_reset();
    write_byte(8'h3C);
    write_byte(8'hC3);
    baudrate = 8'd0;
    run_frame(12, 8'h99, 10, 8'd5, -1);
    exp_bytes.delete();
    exp_bytes.push_back(8'h3C);
    exp_bytes.push_back(8'hC3);
    make_exp(4'd2);
    e = stream_errs(0);
    n_checks++;
    if (timed_out || cap.size() != 30 || e != 0)
      $display("FAIL baud_frame: len %0d bad %0d expected len 30 bad 0", cap.size(), e);
    else n_pass++;
    n_checks++;
    if (empty !== 1'b0) $display("FAIL baud_queued: empty got %b expected 0", empty);
    else n_pass++;
    run_frame(-1, 8'h00, -1, 8'h00, -1);
    exp_bytes.delete();
    exp_bytes.push_back(8'h99);
    make_exp(4'd1);
    e = stream_errs(5);
    n_checks++;
    if (timed_out || cap.size() != 132 || e != 0)
      $display("FAIL baud_refill: len %0d bad %0d expected len 132 bad 0", cap.size(), e);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int act;
    do_reset();
    for (int i = 0; i < 17; i++) write_byte(8'hF0 + 8'(i));
    baudrate = 8'd2;
    send = 1'b1;
    tick();
    send = 1'b0;
    repeat (25) tick();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({TX, busy, empty, over} !== 4'b0010)
      $display("FAIL midrst_after: TX/busy/empty/over got %b expected 0010", {TX, busy, empty, over});
    else n_pass++;
    send = 1'b1;
    tick();
    send = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      if (TX !== 1'b0 || busy !== 1'b0) act++;
      tick();
    end
    n_checks++;
    if (act != 0) $display("FAIL midrst_empty_send: %0d active cycles expected 0", act);
    else n_pass++;
  endtask

  task automatic test_ignored_send();
    int e;
    do_reset();
    write_byte(8'h5A);
    baudrate = 8'd1;
    run_frame(-1, 8'h00, -1, 8'h00, 6);
    exp_bytes.delete();
    exp_bytes.push_back(8'h5A);
    make_exp(4'd1);
    e = stream_errs(1);
    n_checks++;
    if (timed_out || cap.size() != 44 || e != 0)
      $display("FAIL busy_send_frame: len %0d bad %0d expected len 44 bad 0", cap.size(), e);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({busy, empty} !== 2'b01) $display("FAIL busy_send_idle: busy/empty got %b expected 01", {busy, empty});
    else n_pass++;
  endtask

  task automatic test_full_write_pop();
    int e;
    do_reset();
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    baudrate = 8'd0;
    full_after_write = 1'b0;
    run_frame(4, 8'hEE, -1, 8'h00, -1);
    n_checks++;
    if (full_after_write !== 1'b1) $display("FAIL wrpop_full: got %b expected 1", full_after_write);
    else n_pass++;
    n_checks++;
    if (over !== 1'b0) $display("FAIL wrpop_over: got %b expected 0", over);
    else n_pass++;
    run_frame(-1, 8'h00, -1, 8'h00, -1);
    exp_bytes.delete();
    exp_bytes.push_back(8'h2F);
    exp_bytes.push_back(8'hEE);
    make_exp(4'd2);
    e = stream_errs(0);
    n_checks++;
    if (timed_out || cap.size() != 30 || e != 0)
      $display("FAIL wrpop_rest: len %0d bad %0d expected len 30 bad 0", cap.size(), e);
    else n_pass++;
  endtask

  initial begin
    reset       = 1'b1;
    txfifowrite = 1'b0;
    datain      = 8'h00;
    send        = 1'b0;
    baudrate    = 8'd0;
    test_reset();
    test_single_byte();
    test_overflow();
    test_baud_change();
    test_mid_reset();
    test_ignored_send();
    test_full_write_pop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_transmit.md
# frame_transmit

Serial frame transmitter feeding the `receive` block over the single-wire `TX` line. Bytes are queued in a 16-entry transmit FIFO; on a send request the block serialises a frame with start bit, 4-bit byte count, 1–15 data bytes, CRC-8 and stop bit. Bit timing and CRC are the exact format that `receive` decodes, so a `frame_transmit` → `receive` loopback passes data with `dr`, `crce` and `fe` behaving correctly.

## Interface
- No parameters. Bit period is set by the `baudrate` port.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `txfifowrite` input 1: push `datain` into the FIFO this cycle.
- `datain` input 8: byte to queue.
- `send` input 1: request a frame. Ignored while `busy`, or while the FIFO is empty.
- `baudrate` input 8: each bit lasts `baudrate`+1 clocks. Sampled at frame start.
- `TX` output 1: serial line. Idle level is 0.
- `busy` output 1: a frame is in progress.
- `full` output 1: FIFO holds 16 bytes.
- `empty` output 1: FIFO holds 0 bytes.
- `over` output 1: sticky. Set when a write is dropped because the FIFO is full.

## Operation
- **FIFO**
  - 16×8 storage with 4-bit read and write pointers and a 5-bit count.
  - A write is accepted if count < 16, or if a pop occurs in the same cycle.
  - A write that is not accepted sets `over`. Only `reset` clears `over`.
- **Frame bit order:** `1` (start), size[3:0] MSB first, each data byte MSB first in FIFO order, crc[7:0] MSB first, `0` (stop).
  - Total bits = 14 + 8·N.
- **Frame size:** N = min(count, 15), latched when the frame starts. Bytes written during a frame wait for a later frame. Size 0 is never sent.
- **Byte pop:** each data byte is popped into an 8-bit shift register at the first clock of its first bit.
- **CRC-8**
  - Polynomial 0x07, initial value 0x00, bit-serial over the 4 size bits then all data bits.
  - Update per bit: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0x00).
  - Updated once per bit, at the bit's last clock. Cleared at frame start.
- **State machine** (3-bit state; a 5-bit bit counter plus a byte counter track position):
  - IDLE: `TX`=0. `send` & !`empty` → START; latch N and `baudrate`.
  - START: 1 bit of value 1 → SIZE.
  - SIZE: 4 bits → DATA.
  - DATA: 8·N bits → CRC.
  - CRC: 8 bits → STOP.
  - STOP: 1 bit of value 0 → IDLE.
- **Baud counter:** 8 bits. Counts 0..baudrate_latched, then wraps to 0 and advances to the next bit.
  - `baudrate`=0 gives one clock per bit.
  - Changing `baudrate` mid-frame has no effect until the next frame.

## Timing
- **Reset values:** `TX`=0, `busy`=0, `full`=0, `empty`=1, `over`=0, FIFO pointers, count and CRC all 0, state IDLE.
- **Reset mid-frame:** at the next edge, `TX` is 0 and all FIFO contents are discarded. The partial frame is abandoned; `receive` reports an error for it.
- **Frame start:** with `send` high in cycle t (IDLE, not empty), `TX`=1 and `busy`=1 from cycle t+1.
- **Bit hold:** each bit is held exactly `baudrate`+1 cycles.
- **Frame end:** `busy` falls in the cycle after the last stop-bit clock, when the state returns to IDLE. `send` can start the next frame in that cycle; the frame's start bit is then driven one cycle later.
- **Flag timing:** `full` and `empty` are registered and reflect count after the edge. A write and a pop in the same cycle leave count unchanged.
- **Read pointer:** wraps 15→0, and the write pointer wraps the same way. Full versus empty is decided by count, not by pointer equality.
- **Same-cycle events:** `txfifowrite` together with a `send` that starts a frame: the written byte is not included in that frame's N.

## Test plan
- **Single byte:** reset; write 0xA5; `baudrate`=3; pulse `send` → `TX` carries `1`, `0001`, `10100101`, CRC 0x67 (`01100111`), `0`.
  - 22 bits, each 4 clocks, 88 cycles total with `busy` high throughout; `empty`=1 after the pop.
- **Overflow:** 17 consecutive writes of 0x00..0x10 with no send → `full`=1 after the 16th, and the 17th sets `over`=1.
  - A send then transmits size `1111` and bytes 0x00..0x0E.
  - A second send transmits size `0001` with byte 0x0F.
  - 0x10 is never sent.
- **Loopback:** `TX` tied to `receive.RX` with both at `baudrate`=7; send 3 bytes 0x12, 0x34, 0x56 → `receive` FIFO yields them in order with `crce`=0, `fe`=0 and `nf`=0.
- **Baudrate change / refill:**
  - `baudrate`=0: every bit lasts 1 clock.
  - Changing `baudrate` to 5 mid-frame: the current frame keeps 1-clock bits.
  - A byte written mid-frame stays queued and is sent by the next `send`.
- **Mid-frame reset:** assert `reset` during DATA → next cycle `TX`=0, `busy`=0, `empty`=1, `over`=0.
  - `send` with an empty FIFO then produces no activity on `TX`.
- **Ignored / simultaneous requests:**
  - `send` while `busy` → ignored.
  - Write and pop in the same cycle with FIFO full → write accepted, `over` stays 0, `full` stays 1.
